mix_sequencer: RTL

MIX_SEQUENCER -- requirements
Module: mix_sequencer

---
 rtl/mix_pkg.sv | 22 ++
 rtl/mix_accum.sv | 64 ++++++
 rtl/mix_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mix_pkg.sv
// mix_pkg
// Shared definitions for the mix sequencer slice: default geometry,
// saturation limits for the default sample width, and the sequencer
// FSM state type.
package mix_pkg;

   localparam int DEF_NUM_SRC  = 4;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_WAIT_MAX = 8;

   // Two's-complement clamp limits for the default sample width.
   localparam logic [DEF_DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DEF_DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/mix_accum.sv
// mix_accum
// Signed saturating accumulator with synchronous clear and add-enable.
// The next-state value is exported so the sequencer can capture the final
// sum on the same edge that performs the last addition.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   async active-low reset, clears the accumulator
//   clr       in   synchronous clear (wins over add_en)
//   add_en    in   add add_data into the accumulator this cycle
//   add_data  in   DATA_W two's-complement addend
//   acc_next  out  value the accumulator takes at the next edge
module mix_accum
   import mix_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] add_data,
   output logic [DATA_W-1:0] acc_next
);

   localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W:0]   sum_ext;
   logic [DATA_W-1:0] sum_sat;

   always_comb begin
      // One guard bit: overflow shows up as the two top bits disagreeing,
      // and the guard bit then tells which rail to clamp to.
      sum_ext = {acc_q[DATA_W-1], acc_q} + {add_data[DATA_W-1], add_data};
      if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
         sum_sat = sum_ext[DATA_W] ? MIN_V : MAX_V;
      end else begin
         sum_sat = sum_ext[DATA_W-1:0];
      end

      if (clr) begin
         acc_d = '0;
      end else if (add_en) begin
         acc_d = sum_sat;
      end else begin
         acc_d = acc_q;
      end
   end

   assign acc_next = acc_d;

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the values from before the edge, whatever the block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/mix_sequencer.sv
// mix_sequencer
// Once per ADC frame, walks NUM_SRC effect sources in index order, grants
// each enabled source a one-hot ready, and sums the transferred samples in a
// saturating accumulator. A source that stays silent for WAIT_MAX ready
// cycles is skipped and flagged. The finished sum appears on mix_out with a
// one-cycle mix_valid pulse.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   async active-low reset
//   sample_tick  in   one-cycle frame start pulse
//   src_enable   in   per-source mix enable, captured at frame start
//   src_valid    in   per-source data valid
//   src_data     in   packed samples, source i at [i*DATA_W +: DATA_W]
//   flag_clr     in   clears overrun and src_timeout (wins over a set)
//   src_ready    out  one-hot grant, all-zero outside SCAN
//   mix_out      out  last completed mix, held between frames
//   mix_valid    out  one-cycle pulse when mix_out updates
//   busy         out  high whenever the FSM is not IDLE
//   overrun      out  sticky: sample_tick seen while busy
//   src_timeout  out  sticky per-source skip flags
module mix_sequencer
   import mix_pkg::*;
#(
   parameter int NUM_SRC  = DEF_NUM_SRC,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sample_tick,
   input  logic [NUM_SRC-1:0]        src_enable,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic                      flag_clr,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic [DATA_W-1:0]         mix_out,
   output logic                      mix_valid,
   output logic                      busy,
   output logic                      overrun,
   output logic [NUM_SRC-1:0]        src_timeout
);

   localparam int IDX_W  = (NUM_SRC  > 1) ? $clog2(NUM_SRC)  : 1;
   localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SRC - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [NUM_SRC-1:0]  en_q, en_d;
   logic [NUM_SRC-1:0]  src_ready_q, src_ready_d;
   logic [DATA_W-1:0]   mix_out_q, mix_out_d;
   logic                mix_valid_q, mix_valid_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic [NUM_SRC-1:0]  src_timeout_q, src_timeout_d;

   logic [DATA_W-1:0]   src_word [NUM_SRC];
   logic                acc_clr, acc_add, advance;
   logic [DATA_W-1:0]   acc_next;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign src_word[i] = src_data[i*DATA_W +: DATA_W];
   end

   // Accumulator controls are decoded apart from the next-state logic so the
   // accumulator's next value can feed mix_out_d without a combinational
   // path back into the same block.
   assign acc_clr = (state_q == CLEAR);
   assign acc_add = (state_q == SCAN) && en_q[idx_q] &&
                    src_ready_q[idx_q] && src_valid[idx_q];

   mix_accum #(
      .DATA_W (DATA_W)
   ) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .add_en   (acc_add),
      .add_data (src_word[idx_q]),
      .acc_next (acc_next)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case/if tree leaves one unassigned and infers a latch.
      state_d       = state_q;
      idx_d         = idx_q;
      wait_d        = wait_q;
      en_d          = en_q;
      mix_out_d     = mix_out_q;
      mix_valid_d   = 1'b0;
      overrun_d     = overrun_q;
      src_timeout_d = src_timeout_q;
      advance       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sample_tick) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            en_d    = src_enable;
            idx_d   = '0;
            wait_d  = '0;
            state_d = SCAN;
         end
         SCAN: begin
            if (!en_q[idx_q] || acc_add) begin
               advance = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               src_timeout_d[idx_q] = 1'b1;
               advance              = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end

            if (advance) begin
               wait_d = '0;
               if (idx_q == IDX_LAST) begin
                  // Capture the sum including this cycle's addition so
                  // mix_out and mix_valid are both live during DONE.
                  state_d     = DONE;
                  mix_out_d   = acc_next;
                  mix_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (sample_tick && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
      if (flag_clr) begin
         overrun_d     = 1'b0;
         src_timeout_d = '0;
      end

      // Outputs are registered, so they are derived from the next state.
      src_ready_d = '0;
      if ((state_d == SCAN) && en_d[idx_d]) begin
         src_ready_d = NUM_SRC'(1) << idx_d;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         wait_q        <= '0;
         en_q          <= '0;
         src_ready_q   <= '0;
         mix_out_q     <= '0;
         mix_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         src_timeout_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wait_q        <= wait_d;
         en_q          <= en_d;
         src_ready_q   <= src_ready_d;
         mix_out_q     <= mix_out_d;
         mix_valid_q   <= mix_valid_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         src_timeout_q <= src_timeout_d;
      end
   end

   assign src_ready   = src_ready_q;
   assign mix_out     = mix_out_q;
   assign mix_valid   = mix_valid_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign src_timeout = src_timeout_q;

endmodule
